uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//  Reader for the uart RX side: consumes out/rx_done/rx_error, buffers received
//  bytes in a FIFO, and presents them as a valid/ready stream in the clk domain.
//  rx_done/rx_error come from the rx_clk domain, so they are synchronised and
//  edge-detected here. Sits between the uart top and any host/command logic.
// PARAMETERS
//  PAYLOAD_SIZE  8   data width; must match the uart PAYLOAD_SIZE
//  DEPTH         16  FIFO entries; power of two, >=2; ADDR_W=clog2(DEPTH) local
// PORTS
//  clk             in   1             system clock (same clk as the uart top)
//  rst_n           in   1             async active-low reset
//  uart_rx_data    in   PAYLOAD_SIZE  uart out; stable while uart_rx_done high
//  uart_rx_done    in   1             uart rx_done (level, rx_clk domain)
//  uart_rx_error   in   1             uart rx_error (level, rx_clk domain)
//  clear           in   1             sync flush of FIFO + sticky flags
//  m_data          out  PAYLOAD_SIZE  head-of-FIFO byte (first-word fall-through)
//  m_valid         out  1             FIFO non-empty
//  m_ready         in   1             host accepts m_data when m_valid&m_ready
//  count           out  ADDR_W+1      entries held, 0..DEPTH
//  overflow        out  1             sticky: byte dropped because FIFO was full
//  frame_err       out  1             sticky: byte dropped due to uart_rx_error
// BEHAVIOUR
//  Reset: m_valid=0, m_data=0, count=0, overflow=0, frame_err=0, pointers=0,
//   sync flops=0. Memory is not reset.
//  Sync: uart_rx_done and uart_rx_error each pass a 2-flop synchroniser; rise =
//   sync_done & ~done_d (done_d = one more flop). rise is a 1-cycle pulse.
//  Capture: on rise, uart_rx_data is sampled directly (quasi-static, held by the
//   uart while done is high). Latency: a done first seen high at edge E0 gives
//   rise during E1..E2; the write happens at E2; m_valid=1 after E2.
//  Push qualifier at rise: sync_err=1 -> drop, frame_err<=1.
//   Else full & ~pop -> drop, overflow<=1. Else write mem[wr_ptr], wr_ptr++.
//  Pop: m_valid & m_ready -> rd_ptr++ at the edge.
//  Simultaneous push+pop: count unchanged, both pointers advance; allowed
//   when full (no overflow) and when count=1 (m_valid stays 1, new byte next).
//  Pointers: ADDR_W bits, wrap DEPTH-1 -> 0. count is a separate up/down
//   counter; full = (count==DEPTH), empty = (count==0).
//  m_data = mem[rd_ptr] when count!=0, else 0 (combinational read).
//  clear: highest priority; pointers/count/flags <= 0 that edge; a coincident
//   push or pop is discarded. Sync/edge flops are not cleared, so a done level
//   still high does not re-trigger.
//  Sticky flags stay set until clear or reset; a drop never changes count.
//  Async reset mid-frame: all state zeroed immediately; a done still high
//   at release is not a new rise only if done_d was already set, otherwise
//   one byte is captured. This is accepted behaviour.
// STRUCTURE
//  uart_defs.vh (shared include): default PAYLOAD_SIZE, clog2 function.
//  Sub-module uart_sync_edge: 2-flop synchroniser + rise pulse, instanced twice
//   (done; error uses the synced level only). The FIFO is inline in this
//   module. Target is about 200 lines.
// TESTING
//  1. Reset, then done pulse with data 8'hA5 -> m_valid=1 after 3 edges,
//     m_data=A5, count=1. Pop -> m_valid=0, m_data=0.
//  2. Done held high for 40 clk -> exactly one push, count=1.
//  3. With m_ready=0, push 17 bytes 00..10 (DEPTH 16) -> count=16,
//     overflow=1, then pops return 00..0F in order.
//  4. FIFO full with m_ready=1 while a new byte 8'h3C is pushed -> no
//     overflow, count stays 16, and 3C is read out 16th.
//  5. Error high with done, data 8'hFF -> frame_err=1, count=0.
//     clear -> frame_err=0.
//  6. Assert clear in the same cycle as rise and pop with count=3 -> count=0,
//     flags=0, m_valid=0. Assert rst_n=0 mid-stream -> all outputs 0
//     asynchronously.

Source files
------------

// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receive FIFO: default widths, the push
// decision encoding and a constant log2 helper for sizing pointers.
package uart_rx_fifo_pkg;

  localparam int PAYLOAD_SIZE_DEF = 8;
  localparam int DEPTH_DEF        = 16;

  // Outcome of a received-byte event in the current cycle.
  typedef enum logic [1:0] {
    PUSH_IDLE      = 2'd0,
    PUSH_WRITE     = 2'd1,
    PUSH_DROP_ERR  = 2'd2,
    PUSH_DROP_FULL = 2'd3
  } push_e;

  // Ceiling log2, usable in constant expressions (port widths, localparams).
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_edge.sv
// Two-flop synchroniser for a level crossing from the rx_clk domain, plus one
// extra flop so a rising level becomes a single-cycle pulse in the clk domain.
module uart_rx_fifo_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchroniser chain and the delayed copy used for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level = sync_q;
  assign rise  = sync_q & ~prev_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side buffer behind the UART: turns each synchronised rx_done rising
// edge into a FIFO write and presents the FIFO head as a valid/ready stream.
// Bytes flagged by rx_error or arriving while full are dropped and recorded in
// sticky flags.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int PAYLOAD_SIZE = PAYLOAD_SIZE_DEF,
  parameter int DEPTH        = DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [PAYLOAD_SIZE-1:0] uart_rx_data,
  input  logic                    uart_rx_done,
  input  logic                    uart_rx_error,
  input  logic                    clear,
  output logic [PAYLOAD_SIZE-1:0] m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [clog2(DEPTH):0]   count,
  output logic                    overflow,
  output logic                    frame_err
);

  localparam int                ADDR_W   = clog2(DEPTH);
  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic                    done_level_unused;
  logic                    done_rise;
  logic                    err_level;
  logic                    err_rise_unused;

  logic [PAYLOAD_SIZE-1:0] mem [0:DEPTH-1];
  logic [ADDR_W-1:0]       wr_ptr;
  logic [ADDR_W-1:0]       rd_ptr;
  logic [ADDR_W:0]         count_q;
  logic                    overflow_q;
  logic                    frame_err_q;

  logic                    full;
  logic                    empty;
  logic                    pop;
  logic                    push;
  push_e                   push_sel;

  uart_rx_fifo_sync_edge u_sync_done (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (uart_rx_done),
    .level    (done_level_unused),
    .rise     (done_rise)
  );

  // Only the synchronised error level matters; it qualifies the done edge.
  uart_rx_fifo_sync_edge u_sync_err (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (uart_rx_error),
    .level    (err_level),
    .rise     (err_rise_unused)
  );

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign pop     = ~empty & m_ready;
  assign push    = (push_sel == PUSH_WRITE);

  // Classify a received byte: errored bytes are dropped first, then bytes
  // that would not fit. A pop in the same cycle frees a slot, so full+pop
  // still accepts the write.
  always_comb begin
    push_sel = PUSH_IDLE;
    if (done_rise) begin
      if (err_level) begin
        push_sel = PUSH_DROP_ERR;
      end else if (full && !pop) begin
        push_sel = PUSH_DROP_FULL;
      end else begin
        push_sel = PUSH_WRITE;
      end
    end
  end

  // Storage array; not reset, contents are only observed through count.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[wr_ptr] <= uart_rx_data;
    end
  end

  // Pointers, occupancy counter and sticky flags; clear overrides everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else if (clear) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_sel == PUSH_DROP_ERR) begin
        frame_err_q <= 1'b1;
      end
      if (push_sel == PUSH_DROP_FULL) begin
        overflow_q <= 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign m_valid   = ~empty;
  assign m_data    = empty ? '0 : mem[rd_ptr];
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed and randomized checks of uart_rx_fifo against a queue-based model.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] uart_rx_data = 8'h00;
  logic       uart_rx_done = 1'b0;
  logic       uart_rx_error = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [4:0] count;
  logic       overflow;
  logic       frame_err;

  int errors = 0;
  int checks = 0;

  logic [7:0] model_q[$];
  logic       model_ov = 1'b0;
  logic       model_fe = 1'b0;

  uart_rx_fifo #(.PAYLOAD_SIZE(8), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_done  (uart_rx_done),
    .uart_rx_error (uart_rx_error),
    .clear         (clear),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .count         (count),
    .overflow      (overflow),
    .frame_err     (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Model of one received byte while the host is not popping.
  task automatic model_send(input logic [7:0] d, input logic e);
    if (e) model_fe = 1'b1;
    else if (model_q.size() == DEPTH) model_ov = 1'b1;
    else model_q.push_back(d);
  endtask

  task automatic model_clear();
    model_q.delete();
    model_ov = 1'b0;
    model_fe = 1'b0;
  endtask

  task automatic check_state(input string tag);
    logic [7:0] exp_data;
    exp_data = (model_q.size() != 0) ? model_q[0] : 8'h00;
    check({tag, "_count"}, count, model_q.size());
    check({tag, "_valid"}, m_valid, (model_q.size() != 0));
    check({tag, "_data"}, m_data, exp_data);
    check({tag, "_ovf"}, overflow, model_ov);
    check({tag, "_ferr"}, frame_err, model_fe);
  endtask

  // Called at a negedge; leaves the synchroniser fully idle on return.
  task automatic send_byte(input logic [7:0] d, input logic e, input int hold);
    uart_rx_data  = d;
    uart_rx_error = e;
    uart_rx_done  = 1'b1;
    tick(hold);
    uart_rx_done  = 1'b0;
    uart_rx_error = 1'b0;
    tick(4);
    model_send(d, e);
  endtask

  task automatic pop_one(input string tag);
    check({tag, "_pop_data"}, m_data, model_q[0]);
    m_ready = 1'b1;
    tick(1);
    m_ready = 1'b0;
    void'(model_q.pop_front());
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    model_clear();
  endtask

  initial begin
    #1 rst_n = 1'b0;
    tick(3);
    check("rst_count", count, 0);
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 0);
    check("rst_ovf", overflow, 0);
    check("rst_ferr", frame_err, 0);
    rst_n = 1'b1;
    tick(2);

    // 1: first-byte latency and pop back to empty
    uart_rx_data = 8'hA5;
    uart_rx_done = 1'b1;
    tick(1);
    check("t1_e0_valid", m_valid, 0);
    tick(1);
    check("t1_e1_valid", m_valid, 0);
    tick(1);
    check("t1_e2_valid", m_valid, 1);
    check("t1_e2_data", m_data, 8'hA5);
    check("t1_e2_count", count, 1);
    uart_rx_done = 1'b0;
    tick(4);
    model_send(8'hA5, 1'b0);
    pop_one("t1");
    check("t1_after_valid", m_valid, 0);
    check("t1_after_data", m_data, 0);

    // 2: long done level produces exactly one write
    send_byte(8'h5A, 1'b0, 40);
    check("t2_count", count, 1);
    check_state("t2");
    pop_one("t2");
    check_state("t2_empty");

    // 3: overflow on the 17th byte, then in-order drain
    for (int i = 0; i < 17; i++) send_byte(8'(i), 1'b0, 4);
    check("t3_count", count, 16);
    check("t3_ovf", overflow, 1);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t3_order%0d", i), m_data, i);
      pop_one("t3");
    end
    check_state("t3_drained");
    do_clear();
    check_state("t3_clear");

    // 4: push while full with a coincident pop
    for (int i = 0; i < 16; i++) send_byte(8'(8'h40 + i), 1'b0, 4);
    check("t4_full", count, 16);
    uart_rx_data = 8'h3C;
    uart_rx_done = 1'b1;
    tick(2);
    m_ready = 1'b1;
    tick(1);
    m_ready = 1'b0;
    uart_rx_done = 1'b0;
    void'(model_q.pop_front());
    model_q.push_back(8'h3C);
    check("t4_count", count, 16);
    check("t4_ovf", overflow, 0);
    tick(4);
    check_state("t4_settle");
    for (int i = 0; i < 16; i++) begin
      if (i == 15) check("t4_last_3c", m_data, 8'h3C);
      pop_one("t4");
    end
    check_state("t4_drained");

    // 5: errored byte is dropped and flagged
    send_byte(8'hFF, 1'b1, 4);
    check("t5_ferr", frame_err, 1);
    check("t5_count", count, 0);
    do_clear();
    check("t5_clear_ferr", frame_err, 0);

    // 6: clear coincident with rise and pop, no retrigger on held done
    send_byte(8'hE7, 1'b1, 4);
    send_byte(8'h11, 1'b0, 4);
    send_byte(8'h22, 1'b0, 4);
    send_byte(8'h33, 1'b0, 4);
    check_state("t6_pre");
    uart_rx_data = 8'h99;
    uart_rx_done = 1'b1;
    tick(2);
    clear = 1'b1;
    m_ready = 1'b1;
    tick(1);
    clear = 1'b0;
    m_ready = 1'b0;
    model_clear();
    check_state("t6_clr");
    tick(5);
    check("t6_no_retrig", count, 0);
    uart_rx_done = 1'b0;
    tick(4);

    // async reset while holding data and flags
    send_byte(8'h01, 1'b0, 4);
    send_byte(8'h02, 1'b0, 4);
    send_byte(8'h03, 1'b1, 4);
    check_state("t6_prerst");
    #2 rst_n = 1'b0;
    #1;
    check("arst_count", count, 0);
    check("arst_valid", m_valid, 0);
    check("arst_data", m_data, 0);
    check("arst_ferr", frame_err, 0);
    check("arst_ovf", overflow, 0);
    tick(2);
    rst_n = 1'b1;
    model_clear();
    tick(2);
    check_state("arst_release");

    // randomized mix of receives, pops and clears
    for (int op_i = 0; op_i < 90; op_i++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 6) begin
        send_byte(8'($urandom_range(0, 255)), ($urandom_range(0, 7) == 0), $urandom_range(3, 8));
      end else if (op <= 8) begin
        int n;
        n = $urandom_range(1, 2);
        for (int k = 0; k < n; k++) begin
          if (model_q.size() != 0) pop_one($sformatf("rnd%0d", op_i));
        end
      end else begin
        do_clear();
      end
      check_state($sformatf("rnd%0d", op_i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
